// File: rtl/sram_frame_painter_pkg.sv
// Shared types and band helpers for the SRAM frame painter.
// Modes, FSM state encodings and band-boundary constant functions.
package sram_paint_pkg;

    typedef enum logic [1:0] {
        SOLID   = 2'd0,
        HBANDS  = 2'd1,
        VBANDS  = 2'd2,
        CHECKER = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        HOLD   = 2'd3
    } state_e;

    // First band ends here (exclusive)
    function automatic int band_lo(input int res);
        return res / 3;
    endfunction

    // Second band ends here (exclusive)
    function automatic int band_hi(input int res);
        return (2 * res) / 3;
    endfunction

endpackage

// File: rtl/sram_frame_painter_if.sv
// Control and SRAM bus bundle of the frame painter.
// ROI coordinate inputs exist only when PAINT_ROI_EN is defined.
interface sram_frame_painter_if #(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 20,
    parameter int FRAME_CNT_W = 7
`ifdef PAINT_ROI_EN
    ,
    parameter int XW          = 10,
    parameter int YW          = 9
`endif
);

    logic                   i_start;
    logic                   i_abort;
    logic [1:0]             i_mode;
    logic [2*DATA_W-1:0]    i_color_a;
    logic [2*DATA_W-1:0]    i_color_b;
    logic [2*DATA_W-1:0]    i_color_c;
`ifdef PAINT_ROI_EN
    logic [XW-1:0]          i_roi_x0;
    logic [XW-1:0]          i_roi_x1;
    logic [YW-1:0]          i_roi_y0;
    logic [YW-1:0]          i_roi_y1;
`endif
    logic                   o_busy;
    logic                   o_done;
    logic [FRAME_CNT_W-1:0] o_frame_cnt;
    logic                   o_sram_we_n;
    logic [ADDR_W-1:0]      o_sram_addr;
    logic [DATA_W-1:0]      o_sram_dq;

    modport master (
        output i_start, i_abort, i_mode,
        output i_color_a, i_color_b, i_color_c,
`ifdef PAINT_ROI_EN
        output i_roi_x0, i_roi_x1, i_roi_y0, i_roi_y1,
`endif
        input  o_busy, o_done, o_frame_cnt,
        input  o_sram_we_n, o_sram_addr, o_sram_dq
    );

    modport slave (
        input  i_start, i_abort, i_mode,
        input  i_color_a, i_color_b, i_color_c,
`ifdef PAINT_ROI_EN
        input  i_roi_x0, i_roi_x1, i_roi_y0, i_roi_y1,
`endif
        output o_busy, o_done, o_frame_cnt,
        output o_sram_we_n, o_sram_addr, o_sram_dq
    );

endinterface

// File: rtl/paint_color_gen.sv
// Combinational pattern colour for one pixel coordinate.
// Band thresholds are fixed at elaboration from the frame size.
module paint_color_gen
    import sram_paint_pkg::*;
#(
    parameter int H_RES     = 640,
    parameter int V_RES     = 480,
    parameter int DATA_W    = 16,
    parameter int CELL_LOG2 = 5,
    parameter int XW        = $clog2(H_RES),
    parameter int YW        = $clog2(V_RES)
) (
    input  mode_e               mode,
    input  logic [XW-1:0]       x,
    input  logic [YW-1:0]       y,
    input  logic [2*DATA_W-1:0] color_a,
    input  logic [2*DATA_W-1:0] color_b,
    input  logic [2*DATA_W-1:0] color_c,
    output logic [2*DATA_W-1:0] color
);

    localparam logic [XW-1:0] X_B1 = XW'(band_lo(H_RES));
    localparam logic [XW-1:0] X_B2 = XW'(band_hi(H_RES));
    localparam logic [YW-1:0] Y_B1 = YW'(band_lo(V_RES));
    localparam logic [YW-1:0] Y_B2 = YW'(band_hi(V_RES));

    logic cell_odd;

    assign cell_odd = x[CELL_LOG2] ^ y[CELL_LOG2];

    // Pick the colour for the requested pattern
    always_comb begin
        color = color_a;
        unique case (mode)
            SOLID:   color = color_a;
            HBANDS:  color = (y < Y_B1) ? color_a :
                             (y < Y_B2) ? color_b : color_c;
            VBANDS:  color = (x < X_B1) ? color_a :
                             (x < X_B2) ? color_b : color_c;
            CHECKER: color = cell_odd ? color_b : color_a;
            default: color = color_a;
        endcase
    end

endmodule

// File: rtl/sram_frame_painter.sv
// Paints a test pattern frame into async SRAM, 2 words per pixel,
// 3-phase we_n strobe per word. Optional ROI clipping: PAINT_ROI_EN.
module sram_frame_painter
    import sram_paint_pkg::*;
#(
    parameter int H_RES       = 640,
    parameter int V_RES       = 480,
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 20,
    parameter int CELL_LOG2   = 5,
    parameter int FRAME_CNT_W = 7
) (
    input  logic                i_clk,
    input  logic                i_rst,
    sram_frame_painter_if.slave bus
);

    localparam int XW = $clog2(H_RES);
    localparam int YW = $clog2(V_RES);
    localparam int CW = 2 * DATA_W;

    localparam logic [XW-1:0] X_LAST = XW'(H_RES - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(V_RES - 1);

    localparam logic [2:0] S_IDLE   = 3'(IDLE);
    localparam logic [2:0] S_SETUP  = 3'(SETUP);
    localparam logic [2:0] S_STROBE = 3'(STROBE);
    localparam logic [2:0] S_HOLD   = 3'(HOLD);
`ifdef PAINT_ROI_EN
    localparam logic [2:0] S_SKIP   = 3'd4;
`endif

    logic [2:0]             state;
    logic [XW-1:0]          x;
    logic [XW-1:0]          nx;
    logic [YW-1:0]          y;
    logic [YW-1:0]          ny;
    logic                   word_sel;
    logic                   nws;
    logic                   step_pix;
    logic                   last_word;
    logic                   idle;
    logic                   go;
    logic [2:0]             enter_st;

    mode_e                  mode_q;
    mode_e                  gen_mode;
    logic [CW-1:0]          col_a_q;
    logic [CW-1:0]          col_b_q;
    logic [CW-1:0]          col_c_q;
    logic [CW-1:0]          gen_a;
    logic [CW-1:0]          gen_b;
    logic [CW-1:0]          gen_c;
    logic [CW-1:0]          color;
    logic [DATA_W-1:0]      dq_nx;
    logic [ADDR_W-1:0]      addr_inc;

    logic                   busy_q;
    logic                   done_q;
    logic                   we_n_q;
    logic [FRAME_CNT_W-1:0] cnt_q;
    logic [ADDR_W-1:0]      addr_q;
    logic [DATA_W-1:0]      dq_q;

`ifdef PAINT_ROI_EN
    logic [XW-1:0]          rx0_q;
    logic [XW-1:0]          rx1_q;
    logic [YW-1:0]          ry0_q;
    logic [YW-1:0]          ry1_q;
    logic [XW-1:0]          gx0;
    logic [XW-1:0]          gx1;
    logic [YW-1:0]          gy0;
    logic [YW-1:0]          gy1;
    logic                   in_roi;
`endif

    assign idle = (state == S_IDLE);
    assign go   = idle & bus.i_start & ~bus.i_abort;

    // Next pixel coordinate and word select after the current step
    always_comb begin
        step_pix = word_sel;
        addr_inc = ADDR_W'(1);
`ifdef PAINT_ROI_EN
        if (state == S_SKIP) begin
            step_pix = 1'b1;
            addr_inc = ADDR_W'(2);
        end
`endif
        nx  = x;
        ny  = y;
        nws = ~step_pix;
        if (go) begin
            nx  = '0;
            ny  = '0;
            nws = 1'b0;
        end else if (step_pix) begin
            if (x == X_LAST) begin
                nx = '0;
                ny = y + 1'b1;
            end else begin
                nx = x + 1'b1;
            end
        end
        last_word = step_pix & (x == X_LAST) & (y == Y_LAST);
    end

    // Pattern inputs come straight from the ports on the start cycle
    always_comb begin
        gen_mode = idle ? mode_e'(bus.i_mode) : mode_q;
        gen_a    = idle ? bus.i_color_a : col_a_q;
        gen_b    = idle ? bus.i_color_b : col_b_q;
        gen_c    = idle ? bus.i_color_c : col_c_q;
        dq_nx    = nws ? color[DATA_W-1:0] : color[CW-1:DATA_W];
    end

`ifdef PAINT_ROI_EN
    // Clip rectangle check for the pixel about to be entered
    always_comb begin
        gx0      = idle ? bus.i_roi_x0 : rx0_q;
        gx1      = idle ? bus.i_roi_x1 : rx1_q;
        gy0      = idle ? bus.i_roi_y0 : ry0_q;
        gy1      = idle ? bus.i_roi_y1 : ry1_q;
        in_roi   = (nx >= gx0) && (nx <= gx1) &&
                   (ny >= gy0) && (ny <= gy1);
        enter_st = in_roi ? S_SETUP : S_SKIP;
    end
`else
    assign enter_st = S_SETUP;
`endif

    paint_color_gen #(
        .H_RES     (H_RES),
        .V_RES     (V_RES),
        .DATA_W    (DATA_W),
        .CELL_LOG2 (CELL_LOG2),
        .XW        (XW),
        .YW        (YW)
    ) u_color (
        .mode    (gen_mode),
        .x       (nx),
        .y       (ny),
        .color_a (gen_a),
        .color_b (gen_b),
        .color_c (gen_c),
        .color   (color)
    );

    // Frame sequencer: strobe phases, pixel walk and termination
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= S_IDLE;
            x        <= '0;
            y        <= '0;
            word_sel <= 1'b0;
            mode_q   <= SOLID;
            col_a_q  <= '0;
            col_b_q  <= '0;
            col_c_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            we_n_q   <= 1'b1;
            cnt_q    <= '0;
            addr_q   <= '0;
            dq_q     <= '0;
`ifdef PAINT_ROI_EN
            rx0_q    <= '0;
            rx1_q    <= '0;
            ry0_q    <= '0;
            ry1_q    <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            if (idle) begin
                if (go) begin
                    mode_q   <= mode_e'(bus.i_mode);
                    col_a_q  <= bus.i_color_a;
                    col_b_q  <= bus.i_color_b;
                    col_c_q  <= bus.i_color_c;
`ifdef PAINT_ROI_EN
                    rx0_q    <= bus.i_roi_x0;
                    rx1_q    <= bus.i_roi_x1;
                    ry0_q    <= bus.i_roi_y0;
                    ry1_q    <= bus.i_roi_y1;
`endif
                    x        <= '0;
                    y        <= '0;
                    word_sel <= 1'b0;
                    addr_q   <= '0;
                    dq_q     <= dq_nx;
                    busy_q   <= 1'b1;
                    state    <= enter_st;
                end
            end else if (bus.i_abort) begin
                state  <= S_IDLE;
                busy_q <= 1'b0;
                we_n_q <= 1'b1;
            end else begin
                unique case (1'b1)
                    (state == S_SETUP): begin
                        we_n_q <= 1'b0;
                        state  <= S_STROBE;
                    end
                    (state == S_STROBE): begin
                        we_n_q <= 1'b1;
                        state  <= S_HOLD;
                    end
                    default: begin
                        if (last_word) begin
                            state  <= S_IDLE;
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                            cnt_q  <= cnt_q + 1'b1;
                        end else begin
                            x        <= nx;
                            y        <= ny;
                            word_sel <= nws;
                            addr_q   <= addr_q + addr_inc;
                            dq_q     <= dq_nx;
                            state    <= enter_st;
                        end
                    end
                endcase
            end
        end
    end

    assign bus.o_busy      = busy_q;
    assign bus.o_done      = done_q;
    assign bus.o_frame_cnt = cnt_q;
    assign bus.o_sram_we_n = we_n_q;
    assign bus.o_sram_addr = addr_q;
    assign bus.o_sram_dq   = dq_q;

endmodule

// File: tb/tb_sram_frame_painter.sv
// Scoreboard bench for sram_frame_painter on an 8x6 frame.
// Expected SRAM writes and done counts are queued by the stimulus.
module tb_sram_frame_painter;

    localparam int H  = 8;
    localparam int V  = 6;
    localparam int NW = 2 * H * V;

    typedef struct packed {
        logic [7:0]  addr;
        logic [15:0] dq;
    } wr_t;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

`ifdef PAINT_ROI_EN
    sram_frame_painter_if #(
        .DATA_W(16), .ADDR_W(8), .FRAME_CNT_W(2), .XW(3), .YW(3)
    ) bus ();
`else
    sram_frame_painter_if #(
        .DATA_W(16), .ADDR_W(8), .FRAME_CNT_W(2)
    ) bus ();
`endif

    sram_frame_painter #(
        .H_RES(H), .V_RES(V), .DATA_W(16), .ADDR_W(8),
        .CELL_LOG2(1), .FRAME_CNT_W(2)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus.slave)
    );

    wr_t         exp_wr[$];
    int          exp_done[$];
    logic [15:0] mem [0:NW-1];
    int          errors = 0;
    int          checks = 0;
    int          writes = 0;
    int          fc     = 0;
    wr_t         mon_e;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] pix_color(input int m, input int x,
        input int y, input logic [31:0] a, input logic [31:0] b,
        input logic [31:0] c);
        case (m)
            0: return a;
            1: return (y < 2) ? a : (y < 4) ? b : c;
            2: return (x < 2) ? a : (x < 5) ? b : c;
            default: return ((((x >> 1) ^ (y >> 1)) & 1) != 0) ? b : a;
        endcase
    endfunction

    function automatic logic [31:0] memp(input int p);
        return {mem[2*p], mem[2*p+1]};
    endfunction

    task automatic push_words(input int m, input logic [31:0] a,
        input logic [31:0] b, input logic [31:0] c, input int n);
        wr_t e;
        logic [31:0] col;
        for (int w = 0; w < n; w++) begin
            col    = pix_color(m, (w / 2) % H, (w / 2) / H, a, b, c);
            e.addr = 8'(w);
            e.dq   = (w % 2 == 0) ? col[31:16] : col[15:0];
            exp_wr.push_back(e);
        end
    endtask

    // Called at a negedge; returns at the negedge of busy cycle 1
    task automatic start_pulse(input int m, input logic [31:0] a,
        input logic [31:0] b, input logic [31:0] c);
        bus.i_mode    = 2'(m);
        bus.i_color_a = a;
        bus.i_color_b = b;
        bus.i_color_c = c;
        bus.i_start   = 1'b1;
        @(negedge clk);
        bus.i_start   = 1'b0;
        bus.i_mode    = 2'(m + 1);
        bus.i_color_a = ~a;
        bus.i_color_b = ~b;
        bus.i_color_c = ~c;
    endtask

    task automatic run_frame(input string tag, input int poke,
                             output int nb, output int fl);
        int k;
        k  = 1;
        nb = 0;
        fl = -1;
        while (k < 2000) begin
            if (bus.o_busy) nb++;
            if (fl < 0 && bus.o_sram_we_n == 1'b0) fl = k;
            if (!bus.o_busy) break;
            bus.i_start = (k == poke);
            if (k == poke) bus.i_mode = 2'd3;
            @(negedge clk);
            k++;
        end
        bus.i_start = 1'b0;
        if (k >= 2000) begin
            errors++;
            checks++;
            $display("FAIL %s_timeout: busy still %0d", tag, bus.o_busy);
        end
    endtask

    task automatic wait_write(input string tag, input logic [7:0] a);
        int k;
        k = 0;
        while (!(bus.o_sram_we_n == 1'b0 && bus.o_sram_addr == a)
               && k < 1000) begin
            @(negedge clk);
            k++;
        end
        if (k >= 1000) begin
            errors++;
            checks++;
            $display("FAIL %s_timeout: addr %0h never written", tag, a);
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_busy"}, 32'(bus.o_busy), 0);
        chk({tag, "_done"}, 32'(bus.o_done), 0);
        chk({tag, "_cnt"}, 32'(bus.o_frame_cnt), 0);
        chk({tag, "_we_n"}, 32'(bus.o_sram_we_n), 1);
        chk({tag, "_addr"}, 32'(bus.o_sram_addr), 0);
        chk({tag, "_dq"}, 32'(bus.o_sram_dq), 0);
    endtask

    // Monitor: every SRAM write and done pulse is matched to the queues
    always @(negedge clk) begin
        if (bus.o_sram_we_n === 1'b0) begin
            writes++;
            if (exp_wr.size() == 0) begin
                errors++;
                checks++;
                $display("FAIL unexpected_write: addr %0h dq %0h",
                         bus.o_sram_addr, bus.o_sram_dq);
            end else begin
                mon_e = exp_wr.pop_front();
                chk("write_addr", 32'(bus.o_sram_addr), 32'(mon_e.addr));
                chk("write_dq", 32'(bus.o_sram_dq), 32'(mon_e.dq));
            end
            if (int'(bus.o_sram_addr) < NW)
                mem[int'(bus.o_sram_addr)] = bus.o_sram_dq;
        end
        if (bus.o_done === 1'b1) begin
            if (exp_done.size() == 0) begin
                errors++;
                checks++;
                $display("FAIL unexpected_done: cnt %0d", bus.o_frame_cnt);
            end else begin
                chk("done_cnt", 32'(bus.o_frame_cnt),
                    32'(exp_done.pop_front()));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nb;
        int fl;
        int w0;
        logic [31:0] cols [4];
        cols[0] = 32'h1234_5678;
        cols[1] = 32'h9ABC_DEF0;
        cols[2] = 32'h0F0F_F0F0;
        cols[3] = 32'hCAFE_BEEF;

        rst           = 1'b1;
        bus.i_start   = 1'b0;
        bus.i_abort   = 1'b0;
        bus.i_mode    = 2'd0;
        bus.i_color_a = '0;
        bus.i_color_b = '0;
        bus.i_color_c = '0;
`ifdef PAINT_ROI_EN
        bus.i_roi_x0  = 3'd0;
        bus.i_roi_x1  = 3'd7;
        bus.i_roi_y0  = 3'd0;
        bus.i_roi_y1  = 3'd5;
`endif
        repeat (3) @(negedge clk);
        check_reset("init");
        rst = 1'b0;
        @(negedge clk);

        // SOLID frame
        fc = 1;
        push_words(0, 32'hAAAA_5555, 0, 0, NW);
        exp_done.push_back(fc);
        w0 = writes;
        start_pulse(0, 32'hAAAA_5555, 0, 0);
        run_frame("solid", -1, nb, fl);
        chk("solid_busy_cycles", nb, 288);
        chk("solid_first_we", fl, 2);
        chk("solid_we_pulses", writes - w0, 96);
        chk("solid_cnt", 32'(bus.o_frame_cnt), 1);
        chk("solid_queue", exp_wr.size(), 0);
        @(negedge clk);

        // HBANDS frame
        fc = 2;
        push_words(1, 1, 2, 3, NW);
        exp_done.push_back(fc);
        start_pulse(1, 1, 2, 3);
        run_frame("hbands", -1, nb, fl);
        chk("hb_busy_cycles", nb, 288);
        chk("hb_row1", memp(11), 1);
        chk("hb_row3", memp(27), 2);
        chk("hb_row5", memp(43), 3);
        @(negedge clk);

        // VBANDS frame
        fc = 3;
        push_words(2, 1, 2, 3, NW);
        exp_done.push_back(fc);
        start_pulse(2, 1, 2, 3);
        run_frame("vbands", -1, nb, fl);
        chk("vb_col1", memp(33), 1);
        chk("vb_col4", memp(4), 2);
        chk("vb_col5", memp(21), 3);
        @(negedge clk);

        // CHECKER frame, 2x2 cells; counter wraps to 0
        fc = 0;
        push_words(3, 32'h1111_2222, 32'h3333_4444, 0, NW);
        exp_done.push_back(fc);
        start_pulse(3, 32'h1111_2222, 32'h3333_4444, 0);
        run_frame("checker", -1, nb, fl);
        chk("ck_2_0", memp(2), 32'h3333_4444);
        chk("ck_2_2", memp(18), 32'h1111_2222);
        chk("ck_3_3", memp(27), 32'h1111_2222);
        chk("ck_0_2", memp(16), 32'h3333_4444);
        chk("ck_cnt", 32'(bus.o_frame_cnt), 0);
        @(negedge clk);

        // Abort during STROBE of pixel 10 word 0
        push_words(0, 32'h5A5A_A5A5, 0, 0, 21);
        start_pulse(0, 32'h5A5A_A5A5, 0, 0);
        wait_write("abort", 8'd20);
        bus.i_abort = 1'b1;
        @(negedge clk);
        bus.i_abort = 1'b0;
        chk("abort_we_n", 32'(bus.o_sram_we_n), 1);
        chk("abort_busy", 32'(bus.o_busy), 0);
        chk("abort_cnt", 32'(bus.o_frame_cnt), 0);
        repeat (5) @(negedge clk);
        chk("abort_queue", exp_wr.size(), 0);

        // Repaint from 0, with a stray start mid-frame
        fc = 1;
        push_words(0, 32'h0BAD_F00D, 0, 0, NW);
        exp_done.push_back(fc);
        start_pulse(0, 32'h0BAD_F00D, 0, 0);
        run_frame("repaint", 50, nb, fl);
        chk("repaint_busy_cycles", nb, 288);
        chk("repaint_cnt", 32'(bus.o_frame_cnt), 1);
        @(negedge clk);

        // Start and abort together while idle
        bus.i_start = 1'b1;
        bus.i_abort = 1'b1;
        @(negedge clk);
        bus.i_start = 1'b0;
        bus.i_abort = 1'b0;
        repeat (4) @(negedge clk);
        chk("start_abort_busy", 32'(bus.o_busy), 0);
        chk("start_abort_we_n", 32'(bus.o_sram_we_n), 1);

        // Reset mid-frame
        push_words(0, 32'h7777_8888, 0, 0, 6);
        start_pulse(0, 32'h7777_8888, 0, 0);
        wait_write("midrst", 8'd5);
        rst = 1'b1;
        @(negedge clk);
        check_reset("midrst");
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_queue", exp_wr.size(), 0);

        // Four back-to-back frames, start in each done cycle
        for (int f = 0; f < 4; f++) begin
            push_words(0, cols[f], 0, 0, NW);
            exp_done.push_back((f + 1) % 4);
        end
        start_pulse(0, cols[0], 0, 0);
        for (int f = 0; f < 4; f++) begin
            run_frame("b2b", -1, nb, fl);
            chk("b2b_busy_cycles", nb, 288);
            chk("b2b_cnt", 32'(bus.o_frame_cnt), 32'((f + 1) % 4));
            if (f < 3) begin
                start_pulse(0, cols[f + 1], 0, 0);
                chk("b2b_no_gap", 32'(bus.o_busy), 1);
            end
        end

        repeat (4) @(negedge clk);
        chk("final_wr_queue", exp_wr.size(), 0);
        chk("final_done_queue", exp_done.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sram_frame_painter.md
Name: sram_frame_painter

Overview:
Parametrised test-pattern painter that fills a frame buffer in external async SRAM. Pixels are stored as two DATA_W-bit words each, and every word is written with a three-phase we_n strobe. It generalises the fixed 640x480 band painter: frame size, pattern mode and colours are configurable, and it adds start/done/abort handshaking and exact frame termination. It sits between the control FSM and the SRAM arbiter, ahead of the VGA reader.

Parameters:
H_RES, 640, active pixels per line
V_RES, 480, active lines per frame
DATA_W, 16, SRAM data width; one pixel = 2*DATA_W colour bits
ADDR_W, 20, SRAM word address width; must be >= clog2(H_RES*V_RES)+1
CELL_LOG2, 5, checkerboard cell edge = 2**CELL_LOG2 pixels
FRAME_CNT_W, 7, width of the completed-frame counter

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous active-high reset
i_start  in  1  one-cycle request to paint a frame; honoured only when idle
i_abort  in  1  stop the current frame immediately
i_mode  in  2  0 SOLID, 1 HBANDS, 2 VBANDS, 3 CHECKER
i_color_a  in  2*DATA_W  colour A
i_color_b  in  2*DATA_W  colour B
i_color_c  in  2*DATA_W  colour C
o_busy  out  1  frame in progress
o_done  out  1  one-cycle pulse on normal frame completion
o_frame_cnt  out  FRAME_CNT_W  completed frames, wraps
o_sram_we_n  out  1  SRAM write enable, active low
o_sram_addr  out  ADDR_W  SRAM word address
o_sram_dq  out  DATA_W  SRAM write data

Behaviour:
- Reset, synchronous while i_rst=1: state IDLE, o_busy=0, o_done=0, o_frame_cnt=0, o_sram_we_n=1, o_sram_addr=0, o_sram_dq=0, x=y=0, word_sel=0. Reset mid-frame abandons the frame with no done pulse.
- All outputs are registered.
- On i_start in IDLE with i_abort=0:
  - latch i_mode and the three colours; later input changes have no effect until the next start.
  - clear x, y, word_sel and the address counter; o_busy=1 from the next cycle.
- States: IDLE -> SETUP -> STROBE -> HOLD -> SETUP ... -> IDLE.
  - SETUP: o_sram_addr and o_sram_dq valid, we_n=1.
  - STROBE: we_n=0; addr and dq unchanged.
  - HOLD: we_n=1, addr and dq still held; then advance.
- Word order: word_sel=0 drives colour[2*DATA_W-1:DATA_W], word_sel=1 drives colour[DATA_W-1:0].
- Address is {pixel_index, word_sel} with pixel_index = y*H_RES + x. It is produced by an incrementing counter; no multiplier.
- Advance after HOLD: word_sel 0->1; otherwise word_sel=0 and x+1. When x=H_RES-1, x wraps to 0 and y increments.
- Termination: HOLD of word 1 at x=H_RES-1, y=V_RES-1 goes to IDLE. The next cycle has o_busy=0, o_done=1 for one cycle, and o_frame_cnt+1 (wraps at 2**FRAME_CNT_W). No write occurs outside the frame.
- Frame length: exactly 6*H_RES*V_RES cycles of o_busy=1. First we_n low is 2 cycles after the start cycle.
- Pattern selection:
  - SOLID: A.
  - HBANDS: A if y<V_RES/3, B if y<2*V_RES/3, else C (integer division, constants at elaboration).
  - VBANDS: same split on x against H_RES.
  - CHECKER: B if ((x>>CELL_LOG2)^(y>>CELL_LOG2))&1, else A.
- i_abort while busy, any state: next cycle IDLE, we_n=1, o_busy=0, no done, counter unchanged. A write in STROBE is cut short and that word is undefined.
- i_start while busy: ignored.
- i_start and i_abort together in IDLE: abort wins, nothing starts.
- Back-to-back: a start in the o_done cycle is accepted.

Optional Feature:
PAINT_ROI_EN.
- Defined: adds inputs i_roi_x0, i_roi_x1 (clog2(H_RES) bits) and i_roi_y0, i_roi_y1 (clog2(V_RES) bits), latched at start. Pixels outside the inclusive rectangle are skipped: no SETUP/STROBE/HOLD, one cycle per skipped pixel while the address counter still advances. Frame length shortens accordingly; done and counter behaviour are unchanged.
- Undefined: no ROI ports; every pixel is written.

Decomposition:
- Package sram_paint_pkg: mode enum (SOLID, HBANDS, VBANDS, CHECKER), state enum (IDLE, SETUP, STROBE, HOLD), band-boundary constant functions.
- Sub-module paint_color_gen: combinational (mode, x, y, colours) -> 2*DATA_W colour. Band thresholds derived from H_RES/V_RES parameters.

Test Plan:
- H_RES=8, V_RES=6, SOLID, A=32'hAAAA_5555, one start -> o_busy high for exactly 288 cycles; 96 we_n pulses; addr 0..95 in order; dq alternates AAAA/5555; o_done pulses once; o_frame_cnt=1.
- HBANDS, A=1, B=2, C=3 -> rows 0-1 carry A, rows 2-3 carry B, rows 4-5 carry C. VBANDS -> columns 0-1 carry A, 2-4 carry B, 5-7 carry C (thresholds 8/3=2, 16/3=5); checked via an SRAM model.
- CHECKER, CELL_LOG2=1 -> pixel (2,0) = B, (2,2) = A, (3,3) = A, (0,2) = B.
- i_abort in STROBE of pixel 10 -> next cycle we_n=1 and o_busy=0; no o_done; o_frame_cnt unchanged. A new start repaints from addr 0.
- i_start asserted mid-frame and i_start+i_abort in IDLE -> both ignored. i_rst mid-frame -> all outputs at reset values on the next cycle.
- FRAME_CNT_W=2, four frames back-to-back with start in each done cycle -> counter reads 1, 2, 3, 0; no idle gap.
